// File: rtl/alu_op_sequencer.sv
// Sequential initiator for a combinational ALU/adder/mux datapath: latch a command, hold it for a
// settle time, capture the result and return it with a sequence tag. Optional OP_STATS_EN adds op/carry counters.
module alu_op_sequencer #(
   parameter int WIDTH         = 3,
   parameter int OPC_W         = 3,
   parameter int SETTLE_CYCLES = 1,
   parameter int SEQ_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [WIDTH-1:0] cmd_c,
   input  logic [WIDTH-1:0] cmd_d,
   input  logic [WIDTH-1:0] cmd_e,
   input  logic [OPC_W-1:0] cmd_opcode,
   input  logic             cmd_sel_1,
   input  logic [1:0]       cmd_sel_2,
   output logic [WIDTH-1:0] dp_a,
   output logic [WIDTH-1:0] dp_b,
   output logic [WIDTH-1:0] dp_c,
   output logic [WIDTH-1:0] dp_d,
   output logic [WIDTH-1:0] dp_e,
   output logic [OPC_W-1:0] dp_opcode,
   output logic             dp_sel_1,
   output logic [1:0]       dp_sel_2,
   input  logic [WIDTH-1:0] dp_out,
   input  logic             dp_carry_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic [SEQ_W-1:0] rsp_seq
`ifdef OP_STATS_EN
   ,
   output logic [15:0]      op_count,
   output logic [15:0]      carry_count
`endif
);

   // A settle time of 0 would capture before the datapath saw the operands, so it is promoted to 1.
   localparam int         SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_EFF);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RESP
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] settle_cnt;
   logic       accept;
   logic       capture;
   logic       handshake;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      capture    = 1'b0;
      handshake  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept     = 1'b1;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt <= 4'd1) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               handshake  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake flags are flops so that no output depends combinationally on an input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         settle_cnt <= 4'd0;
      end else begin
         if (accept) begin
            cmd_ready  <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
         end else if (state == SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
         if (capture) begin
            rsp_valid <= 1'b1;
         end
         if (handshake) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
         end
      end
   end

   // Datapath drive registers keep the last command after completion; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_a      <= '0;
         dp_b      <= '0;
         dp_c      <= '0;
         dp_d      <= '0;
         dp_e      <= '0;
         dp_opcode <= '0;
         dp_sel_1  <= 1'b0;
         dp_sel_2  <= 2'd0;
      end else if (accept) begin
         dp_a      <= cmd_a;
         dp_b      <= cmd_b;
         dp_c      <= cmd_c;
         dp_d      <= cmd_d;
         dp_e      <= cmd_e;
         dp_opcode <= cmd_opcode;
         dp_sel_1  <= cmd_sel_1;
         dp_sel_2  <= cmd_sel_2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_seq   <= '0;
      end else begin
         if (capture) begin
            rsp_data  <= dp_out;
            rsp_carry <= dp_carry_out;
         end
         if (handshake) begin
            rsp_seq <= rsp_seq + 1'b1;
         end
      end
   end

`ifdef OP_STATS_EN
   // Saturating statistics, updated on the response handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count    <= 16'd0;
         carry_count <= 16'd0;
      end else if (handshake) begin
         if (op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
         end
         if (rsp_carry && carry_count != 16'hFFFF) begin
            carry_count <= carry_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with an XOR datapath stub; compile with
// +define+OP_STATS_EN to also check the statistics counters.
module tb_alu_op_sequencer;

   localparam int SETTLE = 3;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_a, cmd_b, cmd_c, cmd_d, cmd_e;
   logic [2:0] cmd_opcode;
   logic       cmd_sel_1;
   logic [1:0] cmd_sel_2;
   logic [2:0] dp_a, dp_b, dp_c, dp_d, dp_e;
   logic [2:0] dp_opcode;
   logic       dp_sel_1;
   logic [1:0] dp_sel_2;
   logic [2:0] dp_out;
   logic       dp_carry_out;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [2:0] rsp_data;
   logic       rsp_carry;
   logic [3:0] rsp_seq;
`ifdef OP_STATS_EN
   logic [15:0] op_count;
   logic [15:0] carry_count;
`endif

   int checks = 0;
   int errors = 0;
   int cycleCnt = 0;
   int lastAccept = -1;
   int expSeq = 0;
   int expOps = 0;
   int expCarries = 0;

   alu_op_sequencer #(
      .WIDTH(3), .OPC_W(3), .SETTLE_CYCLES(SETTLE), .SEQ_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d), .cmd_e(cmd_e),
      .cmd_opcode(cmd_opcode), .cmd_sel_1(cmd_sel_1), .cmd_sel_2(cmd_sel_2),
      .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_e(dp_e),
      .dp_opcode(dp_opcode), .dp_sel_1(dp_sel_1), .dp_sel_2(dp_sel_2),
      .dp_out(dp_out), .dp_carry_out(dp_carry_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_seq(rsp_seq)
`ifdef OP_STATS_EN
      , .op_count(op_count), .carry_count(carry_count)
`endif
   );

   assign dp_out       = dp_a ^ dp_b;
   assign dp_carry_out = dp_a[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h at t=%0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkStats();
`ifdef OP_STATS_EN
      checkOutput("op_count", 32'(op_count), 32'(expOps));
      checkOutput("carry_count", 32'(carry_count), 32'(expCarries));
`endif
   endtask

   // One full transaction; starts and ends just after a falling edge.
   task automatic applyStimulus(input int holdCycles, input bit backToBack,
                                input bit directed, input logic [2:0] da, input logic [2:0] db);
      logic [2:0] a, b, expData;
      logic       expCarry;
      bit         accepted;
      int         lat;
      a = directed ? da : 3'($urandom);
      b = directed ? db : 3'($urandom);
      cmd_a      = a;
      cmd_b      = b;
      cmd_c      = 3'($urandom);
      cmd_d      = 3'($urandom);
      cmd_e      = 3'($urandom);
      cmd_opcode = directed ? 3'd2 : 3'($urandom);
      cmd_sel_1  = 1'($urandom);
      cmd_sel_2  = directed ? 2'd1 : 2'($urandom);
      cmd_valid  = 1'b1;
      rsp_ready  = (holdCycles == 0);
      expData    = a ^ b;
      expCarry   = a[2];
      accepted   = 1'b0;
      for (int i = 0; i < 40 && !accepted; i++) begin
         if (cmd_ready) accepted = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      checkOutput("accept_timeout", 32'(accepted), 32'd1);
      if (!accepted) return;
      checkOutput("dp_a", 32'(dp_a), 32'(a));
      checkOutput("dp_b", 32'(dp_b), 32'(b));
      checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (backToBack && lastAccept >= 0)
         checkOutput("accept_spacing", 32'(cycleCnt - lastAccept), 32'(SETTLE + 2));
      lastAccept = cycleCnt;
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'(SETTLE));
      checkOutput("rsp_data", 32'(rsp_data), 32'(expData));
      checkOutput("rsp_carry", 32'(rsp_carry), 32'(expCarry));
      checkOutput("rsp_seq", 32'(rsp_seq), 32'(expSeq));
      for (int h = 0; h < holdCycles; h++) begin
         cmd_a     = ~a;
         cmd_valid = 1'b1;
         @(negedge clk);
         checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("bp_data", 32'(rsp_data), 32'(expData));
         checkOutput("bp_carry", 32'(rsp_carry), 32'(expCarry));
         checkOutput("bp_seq", 32'(rsp_seq), 32'(expSeq));
         checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         checkOutput("bp_dp_a", 32'(dp_a), 32'(a));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      expSeq = (expSeq + 1) % 16;
      if (expOps < 65535) expOps++;
      if (expCarry && expCarries < 65535) expCarries++;
      checkOutput("hs_valid", 32'(rsp_valid), 32'd0);
      checkOutput("hs_seq", 32'(rsp_seq), 32'(expSeq));
      checkOutput("hs_cmd_ready", 32'(cmd_ready), 32'd1);
      checkStats();
   endtask

   task automatic resetChecks(input string tag);
      checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, "_rsp_seq"}, 32'(rsp_seq), 32'd0);
      checkOutput({tag, "_dp"}, 32'({dp_a, dp_b, dp_c, dp_d, dp_e, dp_opcode, dp_sel_1, dp_sel_2}), 32'd0);
      checkOutput({tag, "_rsp_data"}, 32'({rsp_data, rsp_carry}), 32'd0);
   endtask

   initial begin
      bit accepted;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      {cmd_a, cmd_b, cmd_c, cmd_d, cmd_e, cmd_opcode, cmd_sel_1, cmd_sel_2} = '0;
      repeat (3) @(negedge clk);
      resetChecks("reset");
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      checkStats();

      $display("[TB] single op");
      applyStimulus(0, 1'b0, 1'b1, 3'b101, 3'b011);

      $display("[TB] backpressure");
      applyStimulus(5, 1'b0, 1'b0, 3'd0, 3'd0);

      $display("[TB] back-to-back with sequence wrap");
      lastAccept = -1;
      for (int n = 0; n < 17; n++) applyStimulus(0, 1'b1, 1'b0, 3'd0, 3'd0);

      $display("[TB] reset during settle");
      cmd_a = 3'($urandom);
      cmd_valid = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 40 && !accepted; i++) begin
         if (cmd_ready) accepted = 1'b1;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      checkOutput("midrst_accept", 32'(accepted), 32'd1);
      rst_n = 1'b0;
      #1;
      resetChecks("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expSeq = 0;
      expOps = 0;
      expCarries = 0;
      for (int i = 0; i < SETTLE + 3; i++) begin
         @(negedge clk);
         checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("midrst_seq", 32'(rsp_seq), 32'd0);
      checkStats();

      $display("[TB] carry pattern");
      applyStimulus(0, 1'b0, 1'b1, 3'b100, 3'($urandom));
      applyStimulus(1, 1'b0, 1'b1, 3'b011, 3'($urandom));
      applyStimulus(0, 1'b0, 1'b1, 3'b110, 3'($urandom));
      applyStimulus(2, 1'b0, 1'b1, 3'b111, 3'($urandom));
`ifdef OP_STATS_EN
      checkOutput("stats_ops4", 32'(op_count), 32'd4);
      checkOutput("stats_carry3", 32'(carry_count), 32'd3);
`endif

      $display("[TB] random ops");
      for (int n = 0; n < 10; n++) applyStimulus(int'($urandom_range(0, 3)), 1'b0, 1'b0, 3'd0, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
